// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: shared encodings for the load/store unit.
//   - access size codes (byte/half/word/reserved)
//   - FSM state codes for lsu_ctrl
//   - byte-lane count of the data bus
//   - is_misaligned(): alignment rule applied to an incoming request
package lsu_ctrl_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WB     = 2'd2;

  // Reserved size is rejected the same way as a genuinely misaligned access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return |off;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for the LSU.
//   Store side: st_size/st_off/st_data -> st_strb (byte enables), st_wdata
//               (data replicated across every lane it could land in).
//   Load side:  ld_size/ld_off/ld_unsigned/ld_rdata -> ld_data (selected lane,
//               sign- or zero-extended; words pass straight through).
module lsu_align
  import lsu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            st_size,
  input  logic [1:0]            st_off,
  input  logic [DATA_WIDTH-1:0] st_data,
  output logic [NUM_LANES-1:0]  st_strb,
  output logic [DATA_WIDTH-1:0] st_wdata,
  input  logic [1:0]            ld_size,
  input  logic [1:0]            ld_off,
  input  logic                  ld_unsigned,
  input  logic [DATA_WIDTH-1:0] ld_rdata,
  output logic [DATA_WIDTH-1:0] ld_data
);

  logic [NUM_LANES-1:0][7:0] lanes;
  logic [7:0]                ld_byte;
  logic [15:0]               ld_half;
  logic                      sgn;

  assign lanes   = ld_rdata;
  assign ld_byte = lanes[ld_off];
  assign ld_half = ld_off[1] ? {lanes[3], lanes[2]} : {lanes[1], lanes[0]};

  always_comb begin
    st_strb  = '1;
    st_wdata = st_data;
    case (st_size)
      SZ_BYTE: begin
        st_strb  = 4'b0001 << st_off;
        st_wdata = {NUM_LANES{st_data[7:0]}};
      end
      SZ_HALF: begin
        st_strb  = 4'b0011 << st_off;
        st_wdata = {(NUM_LANES/2){st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    sgn     = 1'b0;
    ld_data = ld_rdata;
    case (ld_size)
      SZ_BYTE: begin
        sgn     = ~ld_unsigned & ld_byte[7];
        ld_data = {{(DATA_WIDTH-8){sgn}}, ld_byte};
      end
      SZ_HALF: begin
        sgn     = ~ld_unsigned & ld_half[15];
        ld_data = {{(DATA_WIDTH-16){sgn}}, ld_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit between the ALU address and the register file.
//   req_*  : one-cycle request, sampled only while busy=0
//   busy   : request in flight (CPU stalls)
//   misaligned : one-cycle pulse, request rejected without bus activity
//   mem_*  : valid/ready data-memory bus, word-aligned address, byte strobes
//   rd_*   : one-cycle register write of extended load data
// FSM: IDLE -> ACCESS (hold bus request until mem_ready) -> WB (loads only).
// All outputs come straight from flops.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  input  logic                      req_write,
  input  logic [1:0]                req_size,
  input  logic                      req_unsigned,
  input  logic [MEM_ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [ADDRESS_WIDTH-1:0]  req_rd,
  output logic                      busy,
  output logic                      misaligned,
  output logic                      mem_valid,
  output logic                      mem_write,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic                      mem_ready,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      rd_we,
  output logic [ADDRESS_WIDTH-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0]     rd_wdata
);

  logic [1:0]                state_q, state_d;
  logic                      write_q, write_d;
  logic [1:0]                size_q, size_d;
  logic                      uns_q, uns_d;
  logic [1:0]                off_q, off_d;
  logic [ADDRESS_WIDTH-1:0]  rd_q, rd_d;

  logic                      misaligned_q, misaligned_d;
  logic                      mem_valid_q, mem_valid_d;
  logic                      mem_write_q, mem_write_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH/8-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
  logic                      rd_we_q, rd_we_d;
  logic [ADDRESS_WIDTH-1:0]  rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0]     rd_wdata_q, rd_wdata_d;

  logic [DATA_WIDTH/8-1:0]   st_strb;
  logic [DATA_WIDTH-1:0]     st_wdata;
  logic [DATA_WIDTH-1:0]     ld_data;
  logic                      hs;

  // Store steering works on the live request (bus fields are registered at
  // accept); load extraction works on the captured size/offset.
  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .st_size    (req_size),
    .st_off     (req_addr[1:0]),
    .st_data    (req_wdata),
    .st_strb    (st_strb),
    .st_wdata   (st_wdata),
    .ld_size    (size_q),
    .ld_off     (off_q),
    .ld_unsigned(uns_q),
    .ld_rdata   (mem_rdata),
    .ld_data    (ld_data)
  );

  assign hs = mem_valid_q & mem_ready;

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    rd_d         = rd_q;
    misaligned_d = 1'b0;
    mem_valid_d  = mem_valid_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_wdata_d  = mem_wdata_q;
    rd_we_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    rd_wdata_d   = rd_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (is_misaligned(req_size, req_addr[1:0])) begin
            misaligned_d = 1'b1;
          end else begin
            state_d     = ST_ACCESS;
            write_d     = req_write;
            size_d      = req_size;
            uns_d       = req_unsigned;
            off_d       = req_addr[1:0];
            rd_d        = req_rd;
            mem_valid_d = 1'b1;
            mem_write_d = req_write;
            mem_addr_d  = {req_addr[MEM_ADDR_WIDTH-1:2], 2'b00};
            mem_wstrb_d = req_write ? st_strb : '0;
            mem_wdata_d = req_write ? st_wdata : '0;
          end
        end
      end
      ST_ACCESS: begin
        if (hs) begin
          mem_valid_d = 1'b0;
          mem_write_d = 1'b0;
          mem_addr_d  = '0;
          mem_wstrb_d = '0;
          mem_wdata_d = '0;
          if (write_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d    = ST_WB;
            rd_addr_d  = rd_q;
            rd_wdata_d = ld_data;
            rd_we_d    = |rd_q;  // x0 is never written
          end
        end
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      write_q      <= 1'b0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      off_q        <= '0;
      rd_q         <= '0;
      misaligned_q <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wstrb_q  <= '0;
      mem_wdata_q  <= '0;
      rd_we_q      <= 1'b0;
      rd_addr_q    <= '0;
      rd_wdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      rd_q         <= rd_d;
      misaligned_q <= misaligned_d;
      mem_valid_q  <= mem_valid_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_wdata_q  <= mem_wdata_d;
      rd_we_q      <= rd_we_d;
      rd_addr_q    <= rd_addr_d;
      rd_wdata_q   <= rd_wdata_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign misaligned = misaligned_q;
  assign mem_valid  = mem_valid_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign mem_wdata  = mem_wdata_q;
  assign rd_we      = rd_we_q;
  assign rd_addr    = rd_addr_q;
  assign rd_wdata   = rd_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed + randomized transactions against a transaction-level
// model (byte-count/offset arithmetic for strobes, multiplication for lane
// replication, shift/mask/subtract for load extension).
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        busy, misaligned, mem_valid, mem_write, rd_we;
  logic [31:0] mem_addr, mem_wdata, rd_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [4:0]  rd_addr;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .busy(busy), .misaligned(misaligned),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---- reference model ----
  function automatic logic exp_misal(input logic [1:0] sz, input logic [31:0] addr);
    int a;
    a = int'(addr[7:0]);
    if (sz == 2'd3) return 1'b1;
    return (a % (1 << sz)) != 0;
  endfunction

  function automatic logic [3:0] exp_strb(input logic [1:0] sz, input logic [31:0] addr);
    int nbytes, s;
    nbytes = 1 << sz;
    s = ((1 << nbytes) - 1) << (addr % 4);
    return s[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic [31:0] addr,
                                           input logic uns, input logic [31:0] rdata);
    int nbits;
    logic [31:0] v, lim;
    if (sz == 2'd2) return rdata;
    nbits = 8 << sz;
    lim = 32'd1 << nbits;
    v = (rdata >> (8 * (addr % 4))) % lim;
    if (!uns && v >= (lim >> 1)) v = v - lim;
    return v;
  endfunction

  task automatic junk_req();
    req_valid    = 1'($urandom);
    req_write    = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
    req_rd       = 5'($urandom);
  endtask

  // Drive one request from an idle cycle and follow it to completion.
  task automatic xact(input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [4:0] rd, input int wait_n, input logic [31:0] rdata);
    logic ms;
    ms = exp_misal(sz, addr);
    chk("idle_busy", busy, 0);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; req_rd = rd;
    step();
    req_valid = 1'b0;
    if (ms) begin
      chk("mis_pulse", misaligned, 1);
      chk("mis_no_bus", mem_valid, 0);
      chk("mis_busy", busy, 0);
      step();
      chk("mis_one_cycle", misaligned, 0);
      chk("mis_no_bus2", mem_valid, 0);
      chk("mis_no_we", rd_we, 0);
      return;
    end
    chk("acc_no_mis", misaligned, 0);
    for (int w = 0; w <= wait_n; w++) begin
      chk("acc_valid", mem_valid, 1);
      chk("acc_busy", busy, 1);
      chk("acc_write", mem_write, wr);
      chk("acc_addr", mem_addr, addr & 32'hFFFF_FFFC);
      chk("acc_strb", mem_wstrb, wr ? exp_strb(sz, addr) : 4'h0);
      if (wr) chk("acc_wdata", mem_wdata, exp_wdata(sz, wd));
      chk("acc_no_we", rd_we, 0);
      mem_ready = (w == wait_n);
      mem_rdata = (w == wait_n) ? rdata : $urandom;
      if (w < wait_n) junk_req();
      else req_valid = 1'b0;
      step();
    end
    mem_ready = 1'b0;
    req_valid = 1'b0;
    chk("post_valid", mem_valid, 0);
    chk("post_write", mem_write, 0);
    chk("post_addr", mem_addr, 0);
    chk("post_strb", mem_wstrb, 0);
    if (!wr) begin
      chk("wb_busy", busy, 1);
      chk("wb_we", rd_we, rd != 0);
      chk("wb_addr", rd_addr, rd);
      chk("wb_data", rd_wdata, exp_load(sz, addr, uns, rdata));
      junk_req();
      step();
      req_valid = 1'b0;
    end
    chk("done_busy", busy, 0);
    chk("done_we", rd_we, 0);
  endtask

  initial begin
    step();
    chk("rst_busy", busy, 0);
    chk("rst_valid", mem_valid, 0);
    chk("rst_mis", misaligned, 0);
    chk("rst_we", rd_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", rd_wdata, 0);
    rst_n = 1'b1;
    step();

    // directed
    xact(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 5'd0, 0, 32'h0);
    xact(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 5'd5, 0, 32'h80123456);
    xact(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 5'd5, 0, 32'h80123456);
    xact(1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000ABCD, 5'd0, 3, 32'h0);
    xact(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 5'd3, 0, 32'h0);
    xact(1'b0, 2'd1, 1'b0, 32'h6, 32'h0, 5'd9, 0, 32'h7FFF0000);
    xact(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 5'd0, 1, 32'h12345678);
    xact(1'b1, 2'd3, 1'b0, 32'h40, 32'h0, 5'd0, 0, 32'h0);

    // reset in the middle of an ACCESS
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h80;
    req_rd = 5'd7; mem_ready = 1'b0;
    step();
    req_valid = 1'b0;
    chk("rst_mid_pre", mem_valid, 1);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", mem_valid, 0);
    chk("rst_mid_busy", busy, 0);
    step();
    rst_n = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_after_we", rd_we, 0);
      chk("rst_after_valid", mem_valid, 0);
    end
    mem_ready = 1'b0;
    xact(1'b0, 2'd0, 1'b0, 32'h81, 32'h0, 5'd7, 0, 32'h0000_9A00);

    // randomized
    for (int i = 0; i < 300; i++) begin
      xact(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
           5'($urandom), int'($urandom_range(0, 3)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
